// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_subtractor                                               |
// | Brief    : Bit-serial two's-complement subtractor, diff = a - b - bin,     |
// |            LSB first through one full-subtractor cell, valid/ready I/O.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int         c_CW   = $clog2(WIDTH);
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic             r_sa;
  logic             r_sb;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_bnext;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  assign w_x        = r_a_sr[0];
  assign w_y        = r_b_sr[0];
  assign w_d        = w_x ^ w_y ^ r_br;
  assign w_bnext    = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == c_LAST);

  // Gate with rst_n so in_ready stays low for the whole time reset is held.
  assign in_ready  = (r_state == c_IDLE) & rst_n;
  assign out_valid = (r_state == c_DONE);
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_br    <= bin;
            r_sa    <= a[WIDTH-1];
            r_sb    <= b[WIDTH-1];
            r_cnt   <= '0;
            r_state <= c_RUN;
          end
        end
        c_RUN: begin
          r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_res  <= w_res_next;
          r_br   <= w_bnext;
          r_cnt  <= r_cnt + c_CW'(1);
          if (w_last) begin
            r_diff  <= w_res_next;
            r_bout  <= w_bnext;
            // Overflow only possible when operand signs differ.
            r_ovf   <= (r_sa != r_sb) & (w_res_next[WIDTH-1] != r_sa);
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          if (out_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_serial_subtractor                                            |
// | Brief    : Directed self-checking bench for serial_subtractor (WIDTH=8).   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  int checks = 0;
  int passed = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request and returns the number of cycles until out_valid.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                        output int lat);
    int n;
    @(negedge clk);
    a = ia; b = ib; bin = ibin; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else passed++;
    checks++; if (diff !== 8'h00) $display("FAIL rst_diff got=%h exp=00", diff); else passed++;
    checks++; if ({bout, ovf} !== 2'b00) $display("FAIL rst_flags got=%b exp=00", {bout, ovf}); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); else passed++;
  endtask

  task automatic test_vector(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                             input logic [7:0] ed, input logic eb, input logic eo);
    int lat;
    run_op(ia, ib, ibin, lat);
    checks++; if (lat !== 8) $display("FAIL latency %h-%h got=%0d exp=8", ia, ib, lat); else passed++;
    checks++; if (diff !== ed) $display("FAIL diff %h-%h got=%h exp=%h", ia, ib, diff, ed); else passed++;
    checks++; if (bout !== eb) $display("FAIL bout %h-%h got=%b exp=%b", ia, ib, bout, eb); else passed++;
    checks++; if (ovf !== eo) $display("FAIL ovf %h-%h got=%b exp=%b", ia, ib, ovf, eo); else passed++;
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(8'h7F, 8'hFF, 1'b0, lat);
    checks++; if (lat !== 8) $display("FAIL bp_latency got=%0d exp=8", lat); else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 8'h11; b = 8'h00; bin = 1'b0; in_valid = (i % 2) == 0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, out_valid); else passed++;
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); else passed++;
      checks++; if (diff !== 8'h80) $display("FAIL bp_diff[%0d] got=%h exp=80", i, diff); else passed++;
      checks++; if ({bout, ovf} !== 2'b11) $display("FAIL bp_flags[%0d] got=%b exp=11", i, {bout, ovf}); else passed++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); else passed++;
    checks++; if (diff !== 8'h80) $display("FAIL bp_hold_diff got=%h exp=80", diff); else passed++;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_no_capture got=%b exp=1", in_ready); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    a = 8'h10; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (diff !== 8'h00) $display("FAIL midrst_diff got=%h exp=00", diff); else passed++;
    checks++; if ({bout, ovf} !== 2'b00) $display("FAIL midrst_flags got=%b exp=00", {bout, ovf}); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready got=%b exp=0", in_ready); else passed++;
    repeat (10) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%b exp=0", out_valid); else passed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_vector(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_vector(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    test_vector(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    test_vector(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    test_vector(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    test_backpressure();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
